branch_resolve_ctrl: RTL
========================

# branch_resolve_ctrl

Sequencer that owns the branch-resolution step of the core's execute stage. It accepts one branch/jump at a time from issue, requests a compare from the shared ALU, and waits for the `{V,C,N,Z}` flags. It then evaluates the RISC-V branch condition, checks the front-end prediction and drives redirect and flush on a mispredict. It also keeps a saturating mispredict counter and a sticky timeout error.

## Interface
- `FLUSH_CYCLES`, 2: cycles `flush` is held after a mispredict; legal range 1–15.
- `TIMEOUT`, 15: WAIT_FLAGS cycles without `flags_valid` before abort; legal range 1–255.

Clock and reset are fixed as one clock with synchronous, active-high reset:
- `clk`  in  1  clock, all state updates on the rising edge.
- `rst`  in  1  synchronous active-high reset.

Issue side:
- `br_valid`  in  1  branch offered by issue.
- `br_ready`  out  1  high only in IDLE.
- `br_funct3`  in  3  B-type funct3.
- `br_is_jump`  in  1  unconditional (JAL/JALR); flags are not requested.
- `br_pc`  in  32  PC of the branch.
- `br_target`  in  32  computed taken target.
- `br_pred_taken`  in  1  front-end prediction.

ALU side:
- `alu_start`  out  1  one-cycle compare request.
- `flags_valid`  in  1  ALU flags valid this cycle.
- `flags`  in  4  `{V,C,N,Z}`.

Control and result:
- `kill`  in  1  higher-priority squash (exception or older flush).
- `resolved_valid`  out  1  one-cycle result pulse.
- `resolved_taken`  out  1  actual direction; valid with `resolved_valid`.
- `mispredict`  out  1  `resolved_taken != pred`; valid with `resolved_valid`.
- `illegal_funct3`  out  1  funct3 was 010 or 011; valid with `resolved_valid`.
- `redirect_valid`  out  1  one-cycle pulse on mispredict.
- `redirect_pc`  out  32  `taken ? target : pc+4` (mod 2^32); held stable, updated only in RESOLVE.
- `flush`  out  1  squash younger instructions.
- `mispredict_count`  out  16  saturating count.
- `timeout_err`  out  1  sticky until `rst`.

## Operation
- States: IDLE, WAIT_FLAGS, RESOLVE, FLUSH.
- IDLE:
  - Accept on `br_valid & br_ready`.
  - Capture funct3, is_jump, pc, target and pred.
  - Next state is RESOLVE if `br_is_jump`, otherwise WAIT_FLAGS.
- WAIT_FLAGS:
  - `alu_start` is high in the first WAIT_FLAGS cycle only.
  - `flags_valid` is sampled every WAIT_FLAGS cycle, including the first.
  - On `flags_valid`, capture `flags` and go to RESOLVE.
  - A wait counter counts cycles in this state. When it reaches `TIMEOUT` with no `flags_valid`, set `timeout_err` and return to IDLE with no resolve outputs.
- RESOLVE, taken condition:
  - Jump: taken = 1.
  - 000: Z.
  - 001: ~Z.
  - 100: N^V.
  - 101: ~(N^V).
  - 110: ~C.
  - 111: C.
  - 010/011: taken = 0 and `illegal_funct3` = 1.
- RESOLVE, outputs and exit:
  - `resolved_valid` = 1.
  - If mispredict: `redirect_valid` = 1, `redirect_pc` loaded, `mispredict_count` += 1 (saturates at 0xFFFF), next state FLUSH.
  - Otherwise next state is IDLE.
- FLUSH: `flush` = 1 for exactly `FLUSH_CYCLES` cycles, then IDLE.
- `kill`:
  - In any state, next state is IDLE and the wait/flush counters clear.
  - In the same cycle, `kill` combinationally masks `resolved_valid`, `redirect_valid`, `mispredict` and `alu_start`.
  - A killed branch does not increment `mispredict_count`.
  - `kill` does not clear `timeout_err`.
- `kill` and `br_valid` high together in IDLE: no accept, and `br_ready` is forced 0.
- `flags_valid` outside WAIT_FLAGS is ignored.
- Reset values: state IDLE, `br_ready` = 1. Every other output is 0, including `redirect_pc` = 0, `mispredict_count` = 0 and `timeout_err` = 0.
- `rst` mid-operation abandons the branch with no outputs.

## Timing
- All outputs are registered or decoded from state. The only input-to-output combinational paths are the `kill` masking and `br_ready`.
- Conditional branch, accepted at edge 0:
  - Cycle 1: WAIT_FLAGS, `alu_start` high.
  - `flags_valid` in cycle k (k ≥ 1) gives RESOLVE in cycle k+1.
  - Minimum accept-to-result latency is 2 cycles.
- Jump: RESOLVE in cycle 1.
- Mispredict: `flush` high for cycles k+2 .. k+1+`FLUSH_CYCLES`. `br_ready` returns in cycle k+2+`FLUSH_CYCLES`.
- Correct prediction: IDLE and `br_ready` high in cycle k+2. Back-to-back throughput is one branch per 3 cycles minimum.
- Timeout: `timeout_err` rises in the cycle after the `TIMEOUT`-th WAIT_FLAGS cycle without flags; IDLE in that same cycle.

## Test plan
- BEQ, pred 0, flags arrive 1 cycle after `alu_start`, Z = 1, pc = 0x100, target = 0x140:
  - `resolved_taken` = 1, `mispredict` = 1.
  - `redirect_pc` = 0x140, one-cycle redirect pulse.
  - `flush` high 2 cycles, count = 1.
- BLT, pred 0, flags N = 1, V = 1:
  - taken = 0, no redirect, no flush.
  - `br_ready` high 2 cycles after the flags cycle.
- BGEU, pred 1, C = 0, pc = 0xFFFFFFFC:
  - mispredict, `redirect_pc` = 0x00000000 (wrap).
  - `alu_start` exactly one pulse.
- JAL, pred 0: no `alu_start`; RESOLVE in cycle 1, `redirect_pc` = target. Separately, funct3 = 010 with Z = 1 → taken = 0, `illegal_funct3` = 1.
- Timeout:
  - No `flags_valid` for 15 cycles → `timeout_err` = 1, no `resolved_valid`, IDLE.
  - A following branch still resolves normally and `timeout_err` stays 1.
- Kill:
  - `kill` asserted in RESOLVE of a mispredicting branch → no redirect/resolve pulses, count unchanged, IDLE next cycle.
  - `kill` in FLUSH cycle 1 → `flush` drops next cycle.
  - Preset the count to 0xFFFF, then mispredict → stays 0xFFFF.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: execute-stage branch sequencer. Accepts one branch at a
// time, asks the shared ALU for a compare, evaluates the RISC-V condition from
// {V,C,N,Z}, and on a wrong prediction redirects the front end and flushes.
module branch_resolve_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int TIMEOUT      = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [2:0]  br_funct3,
    input  logic        br_is_jump,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_target,
    input  logic        br_pred_taken,
    output logic        alu_start,
    input  logic        flags_valid,
    input  logic [3:0]  flags,
    input  logic        kill,
    output logic        resolved_valid,
    output logic        resolved_taken,
    output logic        mispredict,
    output logic        illegal_funct3,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [15:0] mispredict_count,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_FLAGS = 2'd1,
        S_RESOLVE    = 2'd2,
        S_FLUSH      = 2'd3
    } state_t;

    // Terminal counter values; counters start at 0 on entry to their state.
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  funct3_q;
    logic        is_jump_q;
    logic        pred_q;
    logic [31:0] pc_q;
    logic [31:0] target_q;
    logic [3:0]  flags_q;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic [31:0] redirect_pc_q;
    logic [15:0] mispredict_count_q;
    logic        timeout_err_q;

    logic        accept;
    logic        flag_v, flag_c, flag_n, flag_z;
    logic        taken;
    logic        illegal;
    logic        wrong_pred;
    logic        timeout_hit;
    logic        commit_mispredict;
    logic [31:0] fix_pc;

    assign {flag_v, flag_c, flag_n, flag_z} = flags_q;
    assign accept            = br_valid & br_ready;
    assign wrong_pred        = taken ^ pred_q;
    assign fix_pc            = taken ? target_q : (pc_q + 32'd4);
    assign timeout_hit       = (state_q == S_WAIT_FLAGS) && !flags_valid && (wait_cnt_q == WAIT_LAST);
    // A killed branch never commits its redirect or its count increment.
    assign commit_mispredict = (state_q == S_RESOLVE) && wrong_pred && !kill;

    // Evaluate the branch condition from the captured funct3 and flags
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        if (is_jump_q) begin
            taken = 1'b1;
        end else begin
            case (funct3_q)
                3'b000:  taken = flag_z;
                3'b001:  taken = ~flag_z;
                3'b100:  taken = flag_n ^ flag_v;
                3'b101:  taken = ~(flag_n ^ flag_v);
                3'b110:  taken = ~flag_c;
                3'b111:  taken = flag_c;
                default: illegal = 1'b1;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and wait/flush counter logic; kill overrides everything
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (kill) begin
            state_d     = S_IDLE;
            wait_cnt_d  = 8'd0;
            flush_cnt_d = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    wait_cnt_d  = 8'd0;
                    flush_cnt_d = 4'd0;
                    if (accept) begin
                        state_d = br_is_jump ? S_RESOLVE : S_WAIT_FLAGS;
                    end
                end
                S_WAIT_FLAGS: begin
                    if (flags_valid) begin
                        state_d = S_RESOLVE;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
                S_RESOLVE: begin
                    flush_cnt_d = 4'd0;
                    state_d     = wrong_pred ? S_FLUSH : S_IDLE;
                end
                S_FLUSH: begin
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        flush_cnt_d = flush_cnt_q + 4'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs decoded from state and registers; kill masks the pulses
    always_comb begin
        br_ready         = (state_q == S_IDLE) && !kill;
        alu_start        = (state_q == S_WAIT_FLAGS) && (wait_cnt_q == 8'd0) && !kill;
        resolved_valid   = (state_q == S_RESOLVE) && !kill;
        resolved_taken   = (state_q == S_RESOLVE) && taken;
        illegal_funct3   = (state_q == S_RESOLVE) && illegal;
        mispredict       = commit_mispredict;
        redirect_valid   = commit_mispredict;
        // Show the new target alongside the pulse, then hold it from the register.
        redirect_pc      = commit_mispredict ? fix_pc : redirect_pc_q;
        flush            = (state_q == S_FLUSH);
        mispredict_count = mispredict_count_q;
        timeout_err      = timeout_err_q;
    end

    // Branch capture, counters, redirect target, statistics and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_q           <= 3'd0;
            is_jump_q          <= 1'b0;
            pred_q             <= 1'b0;
            pc_q               <= 32'd0;
            target_q           <= 32'd0;
            flags_q            <= 4'd0;
            wait_cnt_q         <= 8'd0;
            flush_cnt_q        <= 4'd0;
            redirect_pc_q      <= 32'd0;
            mispredict_count_q <= 16'd0;
            timeout_err_q      <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            if (accept) begin
                funct3_q  <= br_funct3;
                is_jump_q <= br_is_jump;
                pred_q    <= br_pred_taken;
                pc_q      <= br_pc;
                target_q  <= br_target;
            end
            if ((state_q == S_WAIT_FLAGS) && flags_valid && !kill) begin
                flags_q <= flags;
            end
            if (commit_mispredict) begin
                redirect_pc_q <= fix_pc;
                if (mispredict_count_q != 16'hFFFF) begin
                    mispredict_count_q <= mispredict_count_q + 16'd1;
                end
            end
            if (timeout_hit && !kill) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

endmodule
